// File: rtl/forth_imem_loader_if.sv
// Byte-stream handshake between a frame source and forth_imem_loader.
// A byte transfers on any clock where byte_valid and byte_ready are both high.
interface forth_imem_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, input  byte_ready);
    modport slave  (input  byte_in, input  byte_valid, output byte_ready);
endinterface

// File: rtl/forth_imem_loader.sv
// Instruction-memory loader for the forth core: parses A5/LEN/data[/CSUM] frames into a
// synchronous instruction RAM and holds the core in reset until a frame completes.
// FORTH_LOADER_CSUM_EN adds a trailing XOR checksum byte to each frame.
module forth_imem_loader #(
    parameter int iaddr_width = 10,
    parameter int instr_width = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    forth_imem_loader_if.slave     stream,
    input  logic [iaddr_width-1:0] cpu_iaddr,
    output logic [instr_width-1:0] cpu_idata,
    output logic                   cpu_reset,
    output logic                   load_done,
    output logic                   load_err
);
    localparam int unsigned DEPTH = 1 << iaddr_width;
    localparam logic [7:0]  MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, RUN, ERR
    } state_t;

    state_t                 state, state_next;
    logic [7:0]             len_lo;
    logic [15:0]            len;
    logic [15:0]            len_next;
    logic [7:0]             lo_byte;
    logic [iaddr_width:0]   waddr;
    logic                   accept;
    logic                   last_word;
    logic                   wr_en;
    logic [instr_width-1:0] mem [DEPTH];
`ifdef FORTH_LOADER_CSUM_EN
    logic [7:0]             csum;
`endif

    assign stream.byte_ready = !reset;
    assign accept            = stream.byte_valid && stream.byte_ready;
    assign len_next          = {stream.byte_in, len_lo};
    // waddr carries one extra bit so a full-depth LEN still matches on its final word
    assign last_word         = (32'(waddr) == (32'(len) - 32'd1));
    assign wr_en             = accept && (state == DATA_HI);

    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                IDLE, RUN, ERR: if (stream.byte_in == MAGIC) state_next = LEN_LO;
                LEN_LO:         state_next = LEN_HI;
                LEN_HI: begin
                    if (len_next == 16'd0 || 32'(len_next) > DEPTH)
                        state_next = ERR;
                    else
                        state_next = DATA_LO;
                end
                DATA_LO:        state_next = DATA_HI;
                DATA_HI: begin
                    if (last_word) begin
`ifdef FORTH_LOADER_CSUM_EN
                        state_next = CSUM;
`else
                        state_next = RUN;
`endif
                    end else begin
                        state_next = DATA_LO;
                    end
                end
`ifdef FORTH_LOADER_CSUM_EN
                CSUM:           state_next = (stream.byte_in == csum) ? RUN : ERR;
`endif
                default:        state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cpu_reset <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_next;
            cpu_reset <= (state_next != RUN);
            load_done <= (state_next == RUN);
            load_err  <= (state_next == ERR);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            case (state)
                LEN_LO: len_lo <= stream.byte_in;
                LEN_HI: begin
                    len   <= len_next;
                    waddr <= '0;
`ifdef FORTH_LOADER_CSUM_EN
                    csum  <= '0;
`endif
                end
                DATA_LO: begin
                    lo_byte <= stream.byte_in;
`ifdef FORTH_LOADER_CSUM_EN
                    csum    <= csum ^ stream.byte_in;
`endif
                end
                DATA_HI: begin
                    waddr <= waddr + (iaddr_width+1)'(1);
`ifdef FORTH_LOADER_CSUM_EN
                    csum  <= csum ^ stream.byte_in;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[waddr[iaddr_width-1:0]] <= {stream.byte_in, lo_byte};
    end

    // Read uses the pre-edge RAM contents, so a same-address write returns old data
    always_ff @(posedge clk) begin
        if (reset) cpu_idata <= '0;
        else       cpu_idata <= mem[cpu_iaddr];
    end
endmodule

// File: tb/tb_forth_imem_loader.sv
// Self-checking bench for forth_imem_loader: frame-level reference model with random
// payloads, lengths and byte_valid gaps; honours FORTH_LOADER_CSUM_EN.
module tb_forth_imem_loader;
    localparam int DEPTH = 1024;
`ifdef FORTH_LOADER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [9:0]  cpu_iaddr;
    logic [15:0] cpu_idata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;

    forth_imem_loader_if bus();

    forth_imem_loader #(.iaddr_width(10), .instr_width(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .stream    (bus),
        .cpu_iaddr (cpu_iaddr),
        .cpu_idata (cpu_idata),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model_mem [DEPTH];
    bit          exp_run;
    bit          exp_err;
    logic [15:0] frame_words[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic status_check(input string tag);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_run));
        check({tag, "_load_done"}, 32'(load_done), 32'(exp_run));
        check({tag, "_load_err"},  32'(load_err),  32'(exp_err));
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        bus.byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_run = 1'b0;
        exp_err = 1'b0;
        status_check("rst");
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_cpu_idata",  32'(cpu_idata),      32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_byte_ready", 32'(bus.byte_ready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int k;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        k = 0;
        while (!bus.byte_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!bus.byte_ready) check("byte_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    // Frame-level model: a legal LEN writes every word; the frame succeeds unless its checksum is bad.
    task automatic send_frame(input int unsigned len_field, input bit bad_csum, input bit gaps);
        logic [7:0] x;
        logic [7:0] lb;
        logic [7:0] hb;
        bit         len_ok;
        send_byte(8'hA5, gaps);
        exp_run = 1'b0;
        exp_err = 1'b0;
        status_check("hdr");
        lb = len_field[7:0];
        hb = len_field[15:8];
        send_byte(lb, gaps);
        send_byte(hb, gaps);
        len_ok = (len_field >= 1) && (len_field <= DEPTH);
        x = 8'h00;
        if (len_ok) begin
            for (int i = 0; i < int'(len_field); i++) begin
                lb = frame_words[i][7:0];
                hb = frame_words[i][15:8];
                x  = x ^ lb ^ hb;
                send_byte(lb, gaps);
                if (i == int'(len_field) - 1) check("pre_release_cpu_reset", 32'(cpu_reset), 32'd1);
                send_byte(hb, gaps);
                model_mem[i] = frame_words[i];
            end
            if (CSUM_EN) send_byte(bad_csum ? x + 8'd1 : x, gaps);
            exp_run = !(CSUM_EN && bad_csum);
            exp_err = CSUM_EN && bad_csum;
        end else begin
            exp_run = 1'b0;
            exp_err = 1'b1;
        end
        status_check("frame");
    endtask

    task automatic read_check(input int addr, input string tag);
        cpu_iaddr = 10'(addr);
        @(posedge clk);
        #1;
        check(tag, 32'(cpu_idata), 32'(model_mem[addr]));
    endtask

    task automatic fill_words(input int n, input bit index_pattern);
        frame_words.delete();
        for (int i = 0; i < n; i++)
            frame_words.push_back(index_pattern ? 16'(i) : 16'($urandom));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          len;
        int unsigned lf;
        bit          bad;
        reset          = 1'b1;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        cpu_iaddr      = '0;
        exp_run        = 1'b0;
        exp_err        = 1'b0;
        apply_reset();

        // Basic two-word load
        frame_words = '{16'hE040, 16'h1234};
        send_frame(2, 1'b0, 1'b0);
        read_check(0, "basic_w0");
        cpu_iaddr = 10'd1;
        @(posedge clk);
        #1;
        check("basic_fetch1", 32'(cpu_idata), 32'h1234);

        // Illegal lengths leave RAM untouched
        send_frame(0, 1'b0, 1'b0);
        read_check(0, "len0_w0");
        read_check(1, "len0_w1");
        send_frame(1025, 1'b0, 1'b0);
        read_check(0, "len1025_w0");
        read_check(1, "len1025_w1");

        if (CSUM_EN) begin
            frame_words = '{16'h1111, 16'h2222};
            send_frame(2, 1'b1, 1'b0);
            read_check(1, "badcsum_w1");
        end
        frame_words = '{16'hE040, 16'h1234};
        send_frame(2, 1'b0, 1'b0);
        read_check(1, "recover_w1");

        // Non-magic bytes are dropped in RUN and in ERR
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        status_check("run_drop");
        fill_words(3, 1'b0);
        send_frame(3, 1'b0, 1'b1);
        read_check(2, "run_restart_w2");
        send_frame(0, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h5A, 1'b0);
        status_check("err_drop");

        // Reset after three data bytes of a four-word frame
        fill_words(4, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(frame_words[0][7:0], 1'b0);
        send_byte(frame_words[0][15:8], 1'b0);
        send_byte(frame_words[1][7:0], 1'b0);
        model_mem[0] = frame_words[0];
        apply_reset();
        read_check(0, "midrst_w0_kept");
        send_frame(4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) read_check(i, "midrst_reload");

        // Randomised short frames
        for (int t = 0; t < 20; t++) begin
            len = $urandom_range(1, 12);
            lf  = 32'(len);
            if ($urandom_range(0, 7) == 0) lf = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1025, 65535);
            bad = CSUM_EN && ($urandom_range(0, 3) == 0);
            fill_words(len, 1'b0);
            send_frame(lf, bad, $urandom_range(0, 1) == 1);
            read_check($urandom_range(0, 3), "rand_lo");
            if (lf == 32'(len)) read_check($urandom_range(0, len - 1), "rand_frame");
        end

        // Full-depth loads
        fill_words(DEPTH, 1'b1);
        send_frame(DEPTH, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) read_check(i, "full_index");
        fill_words(DEPTH, 1'b0);
        send_frame(DEPTH, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) read_check($urandom_range(0, DEPTH - 1), "full_random");
        fill_words(DEPTH, 1'b1);
        send_frame(DEPTH, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) read_check(i, "full_index_gaps");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/forth_imem_loader.md
Name: forth_imem_loader

Overview:
- Instruction-memory writer for the forth core's fetch port. Holds the core in reset, accepts a framed byte stream over a valid/ready handshake, and assembles the bytes into 16-bit instruction words.
- Writes the words into an internal instruction RAM. After a valid frame it releases the core.
- Serves the core's fetches as a synchronous RAM: address in, data one cycle later.

Parameters:
- iaddr_width, 10, instruction address width; RAM depth DEPTH = 2**iaddr_width words.
- instr_width, 16, instruction word width (fixed at 16; byte assembly assumes 2 bytes per word).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- byte_in  input  8  incoming stream byte.
- byte_valid  input  1  byte_in valid this cycle.
- byte_ready  output  1  loader accepts byte this cycle; a transfer occurs when valid & ready.
- cpu_iaddr  input  iaddr_width  core fetch address.
- cpu_idata  output  16  fetched instruction, registered.
- cpu_reset  output  1  reset to core; active-high.
- load_done  output  1  last frame accepted, core running.
- load_err  output  1  last frame rejected.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All state updates on posedge clk.
- Reset values: cpu_reset=1, load_done=0, load_err=0, byte_ready=0, cpu_idata=0, state=IDLE. RAM contents are not reset.
- byte_ready=1 in every state on every cycle not in reset. No back-pressure; the core never stalls the stream.
- Frame format: magic 0xA5; LEN_LO; LEN_HI; then 2*LEN data bytes, little-endian per word (low byte first); then CSUM = XOR of all 2*LEN data bytes.
- Words are written to addresses 0..LEN-1. LEN is a 16-bit word count.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, RUN, ERR. Transitions occur only on accepted bytes.
  - IDLE: 0xA5 -> LEN_LO; other bytes are dropped.
  - LEN_LO: latch low byte -> LEN_HI.
  - LEN_HI: form LEN. If LEN==0 or LEN>DEPTH -> ERR; else clear waddr and csum -> DATA_LO.
  - DATA_LO: latch byte, csum^=byte -> DATA_HI.
  - DATA_HI: write mem[waddr] <= {byte, lo}, csum^=byte, waddr++.
    - If waddr was LEN-1 -> CSUM; else -> DATA_LO.
  - CSUM: byte==csum -> RUN; mismatch -> ERR.
  - RUN and ERR: 0xA5 -> LEN_LO (restart load); other bytes are dropped.
- Outputs are registered from the next state:
  - cpu_reset=0 only in RUN.
  - load_done=1 only in RUN.
  - load_err=1 only in ERR.
  - Entering LEN_LO clears load_done and load_err and reasserts cpu_reset in the same edge.
- Release timing: the edge that accepts a correct CSUM byte drives cpu_reset low. The core executes from address 0 thereafter.
- Fetch port: cpu_idata <= mem[cpu_iaddr] every cycle, regardless of state.
  - One-cycle latency.
  - Read-during-write to the same address returns old data.
- Width rules: waddr is iaddr_width+1 bits wide so that LEN==DEPTH terminates correctly. LEN compare is 16-bit unsigned.
- Partial frame: no timeout. The FSM waits indefinitely mid-frame and the core stays in reset.
- Reset mid-frame: returns to IDLE and cpu_reset=1. Words already written remain in RAM.
- Magic byte inside the payload (DATA_*, LEN_*, CSUM) is treated as data, not as a restart.

Optional Feature:
- Macro FORTH_LOADER_CSUM_EN.
- Defined: CSUM byte is present and checked as above.
- Undefined: the frame has no CSUM byte and the csum register is not implemented. DATA_HI for the last word -> RUN directly, and ERR is reachable only via an illegal LEN.

Test Plan:
- Load A5 02 00 40 E0 34 12 (+ CSUM 0x86 if CSUM_EN) -> mem[0]=E040, mem[1]=1234. cpu_reset falls the edge after the last byte, load_done=1. Fetch addr 1 -> cpu_idata=1234 next cycle.
- A5 00 00 -> ERR, load_err=1, cpu_reset=1, RAM untouched. A5 01 04 (LEN=1025 > DEPTH 1024) -> ERR likewise.
- CSUM_EN: valid payload with CSUM off by 1 -> ERR. Then resend a correct frame -> RUN, load_err=0, load_done=1.
- While in RUN, send 00 FF then A5 -> 00 and FF are ignored. A5 reasserts cpu_reset and clears load_done on the accepting edge.
- Assert reset after 3 data bytes of a 4-word frame -> IDLE, cpu_reset=1, byte_ready=0 during reset. Resend the full frame -> correct contents, RUN.
- LEN=1024 full-depth load with the address pattern as data -> RUN. Every address 0..1023 reads back its index. Random byte_valid gaps give an identical result.
